// File: rtl/thiele_fetch_queue_if.sv
// Signal bundle between the fetch queue, instruction memory and the decode/execute core.
// The fetch queue takes the master side; memory and core sit on the slave side.
interface thiele_fetch_queue_if;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [7:0]  out_opcode;
    logic [7:0]  out_a;
    logic [7:0]  out_b;
    logic [7:0]  out_cost;
    logic        halted;
    logic        fetch_fault;
    logic        align_err;
    logic [31:0] deliver_count;

    modport master (
        output mem_en, mem_addr,
        input  mem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr, out_pc, out_opcode, out_a, out_b, out_cost,
        output halted, fetch_fault, align_err, deliver_count
    );

    modport slave (
        input  mem_en, mem_addr,
        output mem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr, out_pc, out_opcode, out_a, out_b, out_cost,
        input  halted, fetch_fault, align_err, deliver_count
    );
endinterface

// File: rtl/thiele_fetch_queue.sv
// Instruction prefetch queue: issues 1-cycle-latency memory reads under a credit limit,
// buffers returned words in a FIFO and hands them to the core with pre-split fields.
module thiele_fetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    thiele_fetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_last_instr;
    logic [31:0]   r_last_pc;
    logic          r_halted;
    logic          r_fault;
    logic          r_align_err;
    logic [31:0]   r_deliver_count;

    logic          w_out_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_push_halt;
    logic          w_out_of_range;
    logic [CW-1:0] w_occ;
    logic          w_credit;
    logic          w_issue;
    logic [31:0]   w_head_instr;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_instr;

    assign w_out_valid    = (r_count != '0);
    assign w_pop          = w_out_valid && bus.out_ready;
    assign w_out_of_range = ({1'b0, r_fetch_pc} >= PC_LIMIT);

    // A pop this cycle frees its slot immediately, so issue can resume on the first pop.
    assign w_occ    = r_count - CW'(w_pop) + CW'(r_inflight);
    assign w_credit = (w_occ < CW'(DEPTH));
    assign w_issue  = !rst && !bus.redirect_valid && (r_state == ST_FETCH) &&
                      !w_out_of_range && w_credit;

    // Responses die on redirect; once halted, the request issued beside the HALT is dropped.
    assign w_push      = r_inflight && !bus.redirect_valid && (r_state != ST_HALT);
    assign w_push_halt = w_push && (bus.mem_rdata[31:24] == 8'hFF);

    assign w_head_instr = r_fifo_instr[r_rd_ptr];
    assign w_head_pc    = r_fifo_pc[r_rd_ptr];
    assign w_instr      = w_out_valid ? w_head_instr : r_last_instr;

    assign bus.mem_en        = w_issue;
    assign bus.mem_addr      = r_fetch_pc;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_instr     = w_instr;
    assign bus.out_pc        = w_out_valid ? w_head_pc : r_last_pc;
    assign bus.out_opcode    = w_instr[31:24];
    assign bus.out_a         = w_instr[23:16];
    assign bus.out_b         = w_instr[15:8];
    assign bus.out_cost      = w_instr[7:0];
    assign bus.halted        = r_halted;
    assign bus.fetch_fault   = r_fault;
    assign bus.align_err     = r_align_err;
    assign bus.deliver_count = r_deliver_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.mem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_FETCH;
            r_fetch_pc      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_pc   <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_last_instr    <= '0;
            r_last_pc       <= '0;
            r_halted        <= 1'b0;
            r_fault         <= 1'b0;
            r_align_err     <= 1'b0;
            r_deliver_count <= '0;
        end else begin
            if (w_pop) begin
                r_deliver_count <= r_deliver_count + 32'd1;
            end
            if (w_out_valid) begin
                r_last_instr <= w_head_instr;
                r_last_pc    <= w_head_pc;
            end
            r_align_err <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
            r_inflight  <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end

            if (bus.redirect_valid) begin
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_state    <= ST_FETCH;
                r_halted   <= 1'b0;
                r_fault    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_push_halt) begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end else if ((r_state == ST_FETCH) && w_out_of_range) begin
                    r_state <= ST_FAULT;
                    r_fault <= 1'b1;
                end
            end
        end
    end
endmodule
